// File: rtl/cpu_cycle_stretcher.sv
// Qualifies the 2 MHz CPU enable into the 6502 cycle enable and stretches accesses
// to 1 MHz peripherals so each spans one full 1 MHz period with latched bus selects.
module cpu_cycle_stretcher (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        CLK_2en,
    input  logic        CLK_1en,
    input  logic [15:0] A,
    input  logic        RnW,
    input  logic        HALT,
    output logic        CPU_en,
    output logic        STRETCH,
    output logic        PHI2_1M,
    output logic        RnW_1M,
    output logic [7:0]  CS
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic [7:0] cs_dec;
    logic       slow;
    logic       stall;

    // Full-range compares keep every address bit in the decode.
    always_comb begin
        cs_dec    = 8'h00;
        cs_dec[0] = (A >= 16'hFE00) && (A <= 16'hFE07);
        cs_dec[1] = (A >= 16'hFE08) && (A <= 16'hFE0F);
        cs_dec[2] = (A >= 16'hFE10) && (A <= 16'hFE1F);
        cs_dec[3] = (A >= 16'hFE40) && (A <= 16'hFE5F);
        cs_dec[4] = (A >= 16'hFE60) && (A <= 16'hFE7F);
        cs_dec[5] = (A >= 16'hFEC0) && (A <= 16'hFEDF);
        cs_dec[6] = (A >= 16'hFC00) && (A <= 16'hFCFF);
        cs_dec[7] = (A >= 16'hFD00) && (A <= 16'hFDFF);
    end

    assign slow = |cs_dec;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE: stall = HALT | slow;
            WAIT: stall = ~CLK_1en;
        endcase
    end

    assign CPU_en  = nRESET & CLK_2en & ~stall;
    assign STRETCH = nRESET & ((state == WAIT) |
                               ((state == IDLE) & CLK_2en & slow & ~HALT));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= IDLE;
            CS      <= 8'h00;
            PHI2_1M <= 1'b0;
            RnW_1M  <= 1'b1;
        end else if (CLK_2en) begin
            case (state)
                IDLE: begin
                    if (!HALT && slow) begin
                        state   <= WAIT;
                        CS      <= cs_dec;
                        RnW_1M  <= RnW;
                        // Odd phase enters WAIT on the 1 MHz tick, so phase 2 starts one tick later.
                        PHI2_1M <= ~CLK_1en;
                    end
                end
                WAIT: begin
                    if (CLK_1en) begin
                        state   <= IDLE;
                        CS      <= 8'h00;
                        RnW_1M  <= 1'b1;
                        PHI2_1M <= 1'b0;
                    end else begin
                        PHI2_1M <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_cycle_stretcher.sv
// Directed self-checking bench for cpu_cycle_stretcher; enables alternate 1 MHz phase
// on every 2 MHz tick, with one idle CLK between ticks.
module tb_cpu_cycle_stretcher;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        CLK_2en;
    logic        CLK_1en;
    logic [15:0] A;
    logic        RnW;
    logic        HALT;
    logic        CPU_en;
    logic        STRETCH;
    logic        PHI2_1M;
    logic        RnW_1M;
    logic [7:0]  CS;

    int   tests = 0;
    int   fails = 0;
    bit   next1;
    logic en_s;
    logic st_s;

    cpu_cycle_stretcher dut (
        .CLK     (CLK),
        .nRESET  (nRESET),
        .CLK_2en (CLK_2en),
        .CLK_1en (CLK_1en),
        .A       (A),
        .RnW     (RnW),
        .HALT    (HALT),
        .CPU_en  (CPU_en),
        .STRETCH (STRETCH),
        .PHI2_1M (PHI2_1M),
        .RnW_1M  (RnW_1M),
        .CS      (CS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 2 MHz tick: captures the combinational outputs during the enable, then
    // returns at the next falling edge with the registered outputs settled.
    task automatic tick();
        @(negedge CLK);
        CLK_2en = 1'b1;
        CLK_1en = next1;
        #1;
        en_s = CPU_en;
        st_s = STRETCH;
        @(negedge CLK);
        CLK_2en = 1'b0;
        CLK_1en = 1'b0;
        next1   = ~next1;
    endtask

    // Fast ticks until the next tick's CLK_1en value equals want.
    task automatic goto_phase(input bit want);
        A = 16'h8000;
        for (int i = 0; i < 2 && next1 != want; i++) tick();
    endtask

    // Runs one CPU cycle at addr (T0 was the previous tick) and checks length and latched CS.
    task automatic run_cycle(input string tag, input logic [15:0] addr, input logic [7:0] exp_cs);
        bit         first_e1;
        int         n;
        bit         got;
        logic [7:0] cs_first;
        int         exp_len;
        first_e1 = next1;
        A   = addr;
        RnW = 1'b1;
        tick();
        n        = 1;
        got      = en_s;
        cs_first = CS;
        while (!got && n < 6) begin
            tick();
            n++;
            got = en_s;
        end
        if (exp_cs == 8'h00) exp_len = 1;
        else                 exp_len = first_e1 ? 3 : 2;
        check({tag, " len"}, 16'(n), 16'(exp_len));
        check({tag, " cs"}, {8'h00, cs_first}, {8'h00, exp_cs});
        check({tag, " cs_clear"}, {8'h00, CS}, 16'h0000);
    endtask

    int cnt_en;
    logic any_cs, any_st, any_phi;

    initial begin
        nRESET  = 1'b0;
        CLK_2en = 1'b1;
        CLK_1en = 1'b1;
        A       = 16'hFE00;
        RnW     = 1'b1;
        HALT    = 1'b0;
        next1   = 1'b1;
        #12;
        check("rst cpu_en", {15'h0, CPU_en}, 16'h0);
        check("rst stretch", {15'h0, STRETCH}, 16'h0);
        check("rst cs", {8'h00, CS}, 16'h0000);
        check("rst phi2", {15'h0, PHI2_1M}, 16'h0);
        check("rst rnw_1m", {15'h0, RnW_1M}, 16'h1);
        @(negedge CLK);
        CLK_2en = 1'b0;
        CLK_1en = 1'b0;
        nRESET  = 1'b1;

        // Fast sweep.
        A = 16'h8000;
        cnt_en = 0; any_cs = 0; any_st = 0; any_phi = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt_en += int'(en_s);
            any_st  |= st_s;
            any_cs  |= |CS;
            any_phi |= PHI2_1M;
        end
        check("fast cpu_en count", 16'(cnt_en), 16'd8);
        check("fast cs", {15'h0, any_cs}, 16'h0);
        check("fast stretch", {15'h0, any_st}, 16'h0);
        check("fast phi2", {15'h0, any_phi}, 16'h0);

        // Even-phase slow read: T0 on a CLK_1en tick.
        goto_phase(1'b1);
        tick();
        check("even T0 cpu_en", {15'h0, en_s}, 16'h1);
        A = 16'hFE40; RnW = 1'b1;
        tick();
        check("even T1 cpu_en", {15'h0, en_s}, 16'h0);
        check("even T1 stretch", {15'h0, st_s}, 16'h1);
        check("even T1 cs", {8'h00, CS}, 16'h0008);
        check("even T1 rnw_1m", {15'h0, RnW_1M}, 16'h1);
        check("even T1 phi2", {15'h0, PHI2_1M}, 16'h1);
        tick();
        check("even T2 cpu_en", {15'h0, en_s}, 16'h1);
        check("even T2 stretch", {15'h0, st_s}, 16'h1);
        check("even T2 phi2", {15'h0, PHI2_1M}, 16'h0);
        check("even T2 cs", {8'h00, CS}, 16'h0000);

        // Odd-phase slow write: T0 on a tick without CLK_1en.
        A = 16'h8000;
        tick();
        check("odd T0 cpu_en", {15'h0, en_s}, 16'h1);
        A = 16'hFC10; RnW = 1'b0;
        tick();
        check("odd T1 cpu_en", {15'h0, en_s}, 16'h0);
        check("odd T1 stretch", {15'h0, st_s}, 16'h1);
        check("odd T1 phi2", {15'h0, PHI2_1M}, 16'h0);
        check("odd T1 cs", {8'h00, CS}, 16'h0040);
        check("odd T1 rnw_1m", {15'h0, RnW_1M}, 16'h0);
        A = 16'h1234; RnW = 1'b1;
        tick();
        check("odd T2 cpu_en", {15'h0, en_s}, 16'h0);
        check("odd T2 phi2", {15'h0, PHI2_1M}, 16'h1);
        check("odd T2 rnw_1m held", {15'h0, RnW_1M}, 16'h0);
        tick();
        check("odd T3 cpu_en", {15'h0, en_s}, 16'h1);
        check("odd T3 phi2", {15'h0, PHI2_1M}, 16'h0);
        check("odd T3 rnw_1m", {15'h0, RnW_1M}, 16'h1);

        // Decode boundaries on both phases (phase bit = CLK_1en of the first cycle tick).
        for (int ph = 0; ph < 2; ph++) begin
            goto_phase(ph[0]); run_cycle("FE07", 16'hFE07, 8'h01);
            goto_phase(ph[0]); run_cycle("FE08", 16'hFE08, 8'h02);
            goto_phase(ph[0]); run_cycle("FE1F", 16'hFE1F, 8'h04);
            goto_phase(ph[0]); run_cycle("FE20", 16'hFE20, 8'h00);
            goto_phase(ph[0]); run_cycle("FE3F", 16'hFE3F, 8'h00);
            goto_phase(ph[0]); run_cycle("FEDF", 16'hFEDF, 8'h20);
            goto_phase(ph[0]); run_cycle("FEE0", 16'hFEE0, 8'h00);
            goto_phase(ph[0]); run_cycle("FDFF", 16'hFDFF, 8'h80);
        end

        // HALT in IDLE.
        HALT = 1'b1; A = 16'h8000;
        cnt_en = 0; any_st = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt_en += int'(en_s);
            any_st |= st_s;
        end
        check("halt idle cpu_en count", 16'(cnt_en), 16'd0);
        check("halt idle stretch", {15'h0, any_st}, 16'h0);
        HALT = 1'b0;

        // HALT during WAIT: cycle completes on schedule, then HALT holds a pending slow access.
        goto_phase(1'b1);
        tick();
        A = 16'hFE00;
        tick();
        check("halt wait enter cs", {8'h00, CS}, 16'h0001);
        HALT = 1'b1;
        tick();
        check("halt wait cpu_en", {15'h0, en_s}, 16'h1);
        tick();
        check("halt pending cpu_en", {15'h0, en_s}, 16'h0);
        check("halt pending stretch", {15'h0, st_s}, 16'h0);
        check("halt pending cs", {8'h00, CS}, 16'h0000);
        HALT = 1'b0;
        tick();
        check("halt release stretch", {15'h0, st_s}, 16'h1);
        check("halt release cpu_en", {15'h0, en_s}, 16'h0);
        check("halt release cs", {8'h00, CS}, 16'h0001);
        for (int i = 0; i < 4 && !en_s; i++) tick();
        check("halt release completes", {15'h0, en_s}, 16'h1);

        // Reset mid-WAIT with PHI2_1M high.
        goto_phase(1'b1);
        tick();
        A = 16'hFE08; RnW = 1'b0;
        tick();
        check("pre-reset phi2", {15'h0, PHI2_1M}, 16'h1);
        check("pre-reset rnw_1m", {15'h0, RnW_1M}, 16'h0);
        @(negedge CLK);
        CLK_2en = 1'b1; CLK_1en = 1'b1;
        nRESET  = 1'b0;
        #1;
        check("mid rst cs", {8'h00, CS}, 16'h0000);
        check("mid rst phi2", {15'h0, PHI2_1M}, 16'h0);
        check("mid rst rnw_1m", {15'h0, RnW_1M}, 16'h1);
        check("mid rst cpu_en", {15'h0, CPU_en}, 16'h0);
        @(negedge CLK);
        CLK_2en = 1'b0; CLK_1en = 1'b0;
        nRESET  = 1'b1;
        A = 16'h0000; RnW = 1'b1;
        tick();
        check("post rst cpu_en", {15'h0, en_s}, 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_cycle_stretcher.md
# cpu_cycle_stretcher

Sits directly downstream of the timing generator. Qualifies its 2 MHz CPU enable into the actual 6502 cycle enable. Stretches any CPU cycle that addresses a 1 MHz peripheral so the access spans exactly one full 1 MHz period. It also generates the latched 1 MHz-bus chip selects, read/write and phase-2 signal for the CRTC, ACIA, serial ULA, VIAs, ADC and the FRED/JIM pages.

## Interface
- No parameters.
- CLK  in  1  system clock; all enables below are single-CLK pulses
- nRESET  in  1  asynchronous, active-low reset
- CLK_2en  in  1  2 MHz CPU enable from timing generator
- CLK_1en  in  1  1 MHz enable; only ever asserted coincident with CLK_2en
- A  in  16  CPU address bus, valid between CPU_en pulses
- RnW  in  1  CPU read(1)/write(0)
- HALT  in  1  debugger hold; freezes the CPU between cycles
- CPU_en  out  1  qualified CPU cycle enable (combinational)
- STRETCH  out  1  high while a slow cycle is in progress
- PHI2_1M  out  1  1 MHz bus phase-2, registered
- RnW_1M  out  1  RnW latched for the slow access, registered
- CS  out  8  one-hot slow-device selects, registered: [0] CRTC FE00-FE07, [1] ACIA FE08-FE0F, [2] SERPROC FE10-FE1F, [3] SVIA FE40-FE5F, [4] UVIA FE60-FE7F, [5] ADC FEC0-FEDF, [6] FRED FC00-FCFF, [7] JIM FD00-FDFF

## Operation
- `slow` is a combinational decode of A: true iff A falls in any CS range above. All other addresses, including FE20-FE3F and FEE0-FEFF, are fast.
- States: IDLE, WAIT.
- IDLE, on a CLK_2en tick:
  - HALT=1: CPU_en=0, no state change. HALT takes precedence over `slow`.
  - HALT=0, slow=0: CPU_en=1, stay IDLE.
  - HALT=0, slow=1: CPU_en=0. Go to WAIT, latch CS from the decode and RnW_1M←RnW. Set PHI2_1M←1 if CLK_1en=0 on this tick, else PHI2_1M←0.
- WAIT, on a CLK_2en tick:
  - CLK_1en=0: CPU_en=0, PHI2_1M←1.
  - CLK_1en=1: CPU_en=1, PHI2_1M←0, CS←0, RnW_1M←1, go to IDLE.
- In WAIT, HALT and changes on A/RnW are ignored; a started slow cycle always completes.
- STRETCH = (state==WAIT) | (state==IDLE & CLK_2en & slow & ~HALT).
- CPU_en = CLK_2en & ~stall, and is forced 0 while nRESET=0.
- Reset values: state IDLE, CS 0, PHI2_1M 0, RnW_1M 1. CPU_en 0 during reset. STRETCH 0 during reset.

## Timing
- Ticks are counted in CLK_2en pulses. T0 is the CPU_en that starts the cycle.
- Fast cycle: the next CPU_en falls at T0+1.
- Slow cycle, T0 coincident with CLK_1en (even phase):
  - T0+1 (no CLK_1en): enter WAIT, PHI2_1M rises.
  - T0+2 (CLK_1en): CPU_en fires.
  - Cycle length is 2 ticks.
- Slow cycle, T0 not coincident with CLK_1en (odd phase):
  - T0+1 (CLK_1en): enter WAIT, PHI2_1M stays 0.
  - T0+2: PHI2_1M rises.
  - T0+3: CPU_en fires.
  - Cycle length is 3 ticks.
- PHI2_1M is high for exactly one 2 MHz period, the second half of a 1 MHz period. It falls on the same CLK edge that CPU_en is sampled.
- CS and RnW_1M are valid from the CLK edge after the WAIT-entry tick until the CLK edge after the terminating CPU_en tick.
- Back-to-back slow cycles are re-decoded in IDLE on the next CLK_2en. They always take 2 ticks each, since the previous slow cycle ends on a CLK_1en.
- CLK_1en without CLK_2en never occurs. If it does, it is ignored.
- Reset mid-WAIT: outputs return to reset values immediately (asynchronous). After reset release, the first CLK_2en is handled from IDLE.

## Test plan
- Fast sweep: A=8000 for 8 CLK_2en ticks with HALT=0 → 8 CPU_en pulses; CS=0, STRETCH=0, PHI2_1M=0 throughout.
- Even-phase slow read: cycle starts on a CLK_1en tick, A=FE40, RnW=1 → CPU_en suppressed for 1 tick, fires 2 ticks after T0. CS=0000_1000, RnW_1M=1, PHI2_1M high for exactly 1 tick.
- Odd-phase slow write: A=FC10, RnW=0 → CPU_en fires 3 ticks after T0. CS=0100_0000, RnW_1M=0, PHI2_1M low on T0+1 and high on T0+2.
- Decode boundaries: A=FE07→CS[0], FE08→CS[1], FE1F→CS[2], FE20→fast, FE3F→fast, FEDF→CS[5], FEE0→fast, FDFF→CS[7]. Check each on both phases.
- HALT interaction:
  - HALT=1 in IDLE for 5 ticks → no CPU_en.
  - HALT asserted during WAIT → slow cycle still completes on schedule.
  - HALT released with A=FE00 pending → stretch starts on the first tick after release.
- Reset: drop nRESET during WAIT with PHI2_1M=1 → CS=0, PHI2_1M=0, RnW_1M=1 and CPU_en=0 immediately. After release with A=0000 → CPU_en on the first CLK_2en.
